// File: rtl/instr_issue.sv
// instr_issue: instruction memory, PC stepping and RAW-scoreboarded valid/ready issue to the regfile decode port
module instr_issue #(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] PC_RESET   = 32'h0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          load_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
  input  logic [31:0]                   load_data,
  input  logic                          start,
  output logic [31:0]                   instruction,
  output logic                          issue_valid,
  input  logic                          issue_ready,
  input  logic                          wb_valid,
  input  logic [4:0]                    wb_rd,
  output logic [31:0]                   pc,
  output logic                          busy,
  output logic                          halted
);
  localparam int          AW      = $clog2(IMEM_DEPTH);
  localparam logic [31:0] PC_MASK = 32'(IMEM_DEPTH * 4 - 1);
  localparam logic [31:0] ECALL   = 32'h0000_0073;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, STALL, HALT} state_t;
  state_t      state, state_next;
  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] pending, pending_next, pc_next, pc_inc, instr_next, word;
  logic [AW-1:0] rd_idx;
  logic        xfer, writes_rd, loadable;
  function automatic logic hazard(input logic [31:0] p, input logic [4:0] a, input logic [4:0] b);
    return p[a] | p[b];
  endfunction
  assign xfer      = state == ISSUE && issue_ready;
  assign loadable  = state == IDLE || state == HALT;
  assign pc_inc    = (pc + 32'd4) & PC_MASK;
  assign rd_idx    = state == FETCH ? pc[2 +: AW] : pc_inc[2 +: AW];
  assign word      = imem[rd_idx];
  assign writes_rd = instruction[11:7] != 5'd0 &&
                     instruction[6:0] inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011};
  always_comb begin
    pending_next = pending;
    if (wb_valid) pending_next[wb_rd] = 1'b0;
    if (xfer && writes_rd) pending_next[instruction[11:7]] = 1'b1;
    pending_next[0] = 1'b0;
  end
  // A newly captured instruction is checked against the scoreboard as it will
  // stand after this edge, so issue_valid never rises for a hazardous word.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    instr_next = instruction;
    case (state)
      IDLE, HALT: if (start) begin
        state_next = FETCH;
        pc_next    = PC_RESET;
      end
      FETCH: begin
        instr_next = word;
        state_next = hazard(pending_next, word[19:15], word[24:20]) ? STALL : ISSUE;
      end
      ISSUE: if (xfer) begin
        if (instruction == ECALL) state_next = HALT;
        else begin
          pc_next    = pc_inc;
          instr_next = word;
          state_next = hazard(pending_next, word[19:15], word[24:20]) ? STALL : ISSUE;
        end
      end
      STALL: state_next = hazard(pending, instruction[19:15], instruction[24:20]) ? STALL : ISSUE;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= PC_RESET;
      instruction <= '0;
      pending     <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instruction <= instr_next;
      pending     <= pending_next;
    end
  end
  always_ff @(posedge clock) if (load_en && loadable) imem[load_addr] <= load_data;
  assign issue_valid = state == ISSUE;
  assign busy        = state == FETCH || state == ISSUE || state == STALL;
  assign halted      = state == HALT;
endmodule

// File: tb/tb_instr_issue.sv
// tb_instr_issue: scoreboard bench for instr_issue with a program-walk reference and a pending-register model
module tb_instr_issue;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  logic        clock = 1'b0, reset = 1'b1, load_en = 1'b0, start = 1'b0, issue_ready = 1'b0, wb_valid = 1'b0;
  logic [5:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] instruction, pc;
  logic        issue_valid, busy, halted;
  logic        s_reset = 1'b1, s_load_en = 1'b0, s_start = 1'b0, s_ready = 1'b0, s_wb_valid = 1'b0;
  logic [1:0]  s_load_addr = '0;
  logic [31:0] s_load_data = '0;
  logic [4:0]  s_wb_rd = '0;
  logic [31:0] s_instruction, s_pc;
  logic        s_valid, s_busy, s_halted;
  int          checks = 0, failures = 0, cyc = 0, start_edge = 0;
  logic [31:0] tb_mem [64];
  logic [31:0] mpend = '0;
  logic [63:0] exp_q [$];
  int          xfer_edges [$];
  logic [31:0] s_pcs [$];
  bit          rnd_mode = 0;

  instr_issue #(.IMEM_DEPTH(64), .PC_RESET(32'h0)) dut (
    .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .instruction(instruction), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .pc(pc), .busy(busy), .halted(halted));

  instr_issue #(.IMEM_DEPTH(4), .PC_RESET(32'h0)) dut_small (
    .clock(clock), .reset(s_reset), .load_en(s_load_en), .load_addr(s_load_addr), .load_data(s_load_data),
    .start(s_start), .instruction(s_instruction), .issue_valid(s_valid), .issue_ready(s_ready),
    .wb_valid(s_wb_valid), .wb_rd(s_wb_rd), .pc(s_pc), .busy(s_busy), .halted(s_halted));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic bit writes(input logic [31:0] w);
    return w[11:7] != 5'd0 && (w[6:0] == 7'h33 || w[6:0] == 7'h13 || w[6:0] == 7'h37 ||
                               w[6:0] == 7'h17 || w[6:0] == 7'h03);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int edge_at(input int i);
    return i < xfer_edges.size() ? xfer_edges[i] : -1;
  endfunction

  // Monitor: compares every transfer with the expected program order and
  // checks offered instructions against the pending-register model.
  initial begin
    bit          have_prev = 0, prev_valid = 0, prev_xfer = 0, x;
    logic [31:0] prev_instr = '0, prev_pc = '0;
    logic [63:0] e;
    forever begin
      @(negedge clock);
      if (reset) begin
        mpend = '0;
        exp_q.delete();
        have_prev = 0;
      end else begin
        x = issue_valid && issue_ready;
        if (issue_valid) begin
          checks++;
          if (mpend[instruction[19:15]] || mpend[instruction[24:20]]) begin
            failures++;
            $display("FAIL hazard_offer: instr %h at pc %h offered while pending=%h, required no pending source", instruction, pc, mpend);
          end
        end
        if (have_prev && prev_valid && !prev_xfer) begin
          checks++;
          if (!issue_valid || instruction !== prev_instr || pc !== prev_pc) begin
            failures++;
            $display("FAIL offer_hold: got valid=%b instr=%h pc=%h, required valid=1 instr=%h pc=%h", issue_valid, instruction, pc, prev_instr, prev_pc);
          end
        end
        if (x) begin
          xfer_edges.push_back(cyc + 1);
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL xfer_extra: got pc=%h instr=%h, required no transfer", pc, instruction);
          end else begin
            e = exp_q.pop_front();
            if ({pc, instruction} !== e) begin
              failures++;
              $display("FAIL xfer_order: got pc=%h instr=%h, required pc=%h instr=%h", pc, instruction, e[63:32], e[31:0]);
            end
          end
        end
        if (wb_valid) mpend[wb_rd] = 1'b0;
        if (x && writes(instruction)) mpend[instruction[11:7]] = 1'b1;
        mpend[0] = 1'b0;
        if (start) start_edge = cyc + 1;
        prev_valid = issue_valid;
        prev_xfer  = x;
        prev_instr = instruction;
        prev_pc    = pc;
        have_prev  = 1;
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (!s_reset && s_valid && s_ready) s_pcs.push_back(s_pc);
  end

  // Random ready and write-back of registers the model holds as pending.
  initial forever begin
    int c [$];
    @(posedge clock);
    #1;
    if (rnd_mode) begin
      issue_ready = $urandom_range(0, 3) != 0;
      wb_valid = 1'b0;
      c.delete();
      for (int r = 1; r < 32; r++) if (mpend[r]) c.push_back(r);
      if (c.size() > 0 && $urandom_range(0, 1) == 1) begin
        wb_valid = 1'b1;
        wb_rd = 5'(c[$urandom_range(0, c.size() - 1)]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic load(input int a, input logic [31:0] d, input bit honoured);
    load_en = 1'b1;
    load_addr = 6'(a);
    load_data = d;
    step();
    load_en = 1'b0;
    if (honoured) tb_mem[a] = d;
  endtask

  task automatic start_run();
    logic [31:0] p = 32'h0, w;
    xfer_edges.delete();
    for (int i = 0; i < 256; i++) begin
      w = tb_mem[p[7:2]];
      exp_q.push_back({p, w});
      if (w == ECALL) break;
      p = (p + 32'd4) & 32'hFF;
    end
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_halt(input int limit);
    int n = 0;
    while (!halted && n < limit) begin
      step();
      n++;
    end
    checks++;
    if (!halted) begin
      failures++;
      $display("FAIL halt_timeout: halted=0 after %0d cycles, required 1", limit);
    end
    chk("exp_drained", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0] ops [7];
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63};
    return {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
            5'($urandom_range(0, 7)), ops[$urandom_range(0, 6)]};
  endfunction

  initial begin
    int n, len;
    logic [31:0] hold_i, hold_p;
    for (int i = 0; i < 64; i++) tb_mem[i] = '0;
    step();
    step();
    reset = 1'b0;
    s_reset = 1'b0;
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_valid", 32'(issue_valid), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    // RAW stall on the add, released by write-backs at N+4 and N+5
    load(0, 32'h00500513, 1);
    load(1, 32'h00500593, 1);
    load(2, 32'h00b50633, 1);
    load(3, ECALL, 1);
    issue_ready = 1'b1;
    start_run();
    n = start_edge;
    chk("t1_fetch_valid", 32'(issue_valid), 32'd0);
    step();
    chk("t1_first_valid", 32'(issue_valid), 32'd1);
    chk("t1_first_pc", pc, 32'h0);
    step();
    step();
    chk("t1_stall_valid", 32'(issue_valid), 32'd0);
    chk("t1_stall_pc", pc, 32'h8);
    chk("t1_stall_instr", instruction, 32'h00b50633);
    chk("t1_stall_busy", 32'(busy), 32'd1);
    wb_valid = 1'b1;
    wb_rd = 5'd10;
    step();
    wb_rd = 5'd11;
    step();
    wb_valid = 1'b0;
    wait_halt(40);
    chk("t1_edge_i0", 32'(edge_at(0)), 32'(n + 2));
    chk("t1_edge_i1", 32'(edge_at(1)), 32'(n + 3));
    chk("t1_edge_add", 32'(edge_at(2)), 32'(n + 7));
    chk("t1_edge_ecall", 32'(edge_at(3)), 32'(n + 8));
    while (cyc < n + 9) step();
    chk("t1_halted", 32'(halted), 32'd1);
    chk("t1_halt_busy", 32'(busy), 32'd0);

    // ready held low while offering; a load while busy must be ignored
    do_reset();
    load(0, 32'h00500513, 1);
    load(1, ECALL, 1);
    issue_ready = 1'b0;
    start_run();
    n = start_edge;
    step();
    hold_i = instruction;
    hold_p = pc;
    chk("t2_offer_valid", 32'(issue_valid), 32'd1);
    chk("t2_offer_instr", hold_i, 32'h00500513);
    load(1, 32'h00000013, 0);
    chk("t2_hold_instr", instruction, hold_i);
    chk("t2_hold_pc", pc, hold_p);
    step();
    chk("t2_hold_valid", 32'(issue_valid), 32'd1);
    issue_ready = 1'b1;
    step();
    wait_halt(20);
    chk("t2_edge_first", 32'(edge_at(0)), 32'(n + 4));
    chk("t2_xfer_count", 32'(xfer_edges.size()), 32'd2);
    start_run();
    wait_halt(20);
    chk("t2_readback_count", 32'(xfer_edges.size()), 32'd2);

    // x0 writer and x0 readers issue back to back
    do_reset();
    load(0, 32'h00100013, 1);
    load(1, 32'h00000533, 1);
    load(2, 32'h00000633, 1);
    load(3, ECALL, 1);
    start_run();
    n = start_edge;
    wait_halt(20);
    for (int i = 0; i < 4; i++) chk("t3_edge", 32'(edge_at(i)), 32'(n + 2 + i));

    // same-cycle write-back and re-set of x10: set wins
    do_reset();
    load(0, 32'h00500513, 1);
    load(1, 32'h00500513, 1);
    load(2, 32'h00b50633, 1);
    load(3, ECALL, 1);
    start_run();
    n = start_edge;
    step();
    step();
    wb_valid = 1'b1;
    wb_rd = 5'd10;
    step();
    wb_valid = 1'b0;
    chk("t4_stall_valid", 32'(issue_valid), 32'd0);
    step();
    step();
    chk("t4_still_stalled", 32'(issue_valid), 32'd0);
    wb_valid = 1'b1;
    wb_rd = 5'd10;
    step();
    wb_valid = 1'b0;
    wait_halt(20);
    chk("t4_edge_add", 32'(edge_at(2)), 32'(n + 8));
    chk("t4_edge_ecall", 32'(edge_at(3)), 32'(n + 9));

    // PC wrap on a 4-entry memory
    s_load_en = 1'b1;
    for (int a = 0; a < 4; a++) begin
      s_load_addr = 2'(a);
      s_load_data = 32'h00000013;
      step();
    end
    s_load_en = 1'b0;
    s_ready = 1'b1;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    repeat (10) step();
    for (int i = 0; i < 6; i++) chk("t5_wrap_pc", i < s_pcs.size() ? s_pcs[i] : 32'hFFFF_FFFF, 32'((i % 4) * 4));
    s_reset = 1'b1;
    step();
    s_reset = 1'b0;
    chk("t5_rst_valid", 32'(s_valid), 32'd0);

    // reset while stalled, then restart from PC_RESET with a clear scoreboard
    do_reset();
    load(0, 32'h00500513, 1);
    load(1, 32'h00500593, 1);
    load(2, 32'h00b50633, 1);
    load(3, ECALL, 1);
    start_run();
    step();
    step();
    step();
    chk("t6_pre_stall", 32'(issue_valid), 32'd0);
    do_reset();
    chk("t6_rst_instruction", instruction, 32'h0);
    chk("t6_rst_valid", 32'(issue_valid), 32'd0);
    chk("t6_rst_pc", pc, 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_halted", 32'(halted), 32'd0);
    load(0, 32'h00b50633, 1);
    load(1, ECALL, 1);
    start_run();
    n = start_edge;
    wait_halt(20);
    chk("t6_edge_add", 32'(edge_at(0)), 32'(n + 2));

    // random programs with random ready and write-back timing
    do_reset();
    rnd_mode = 1;
    for (int k = 0; k < 12; k++) begin
      len = (k == 5) ? 64 : int'($urandom_range(2, 16));
      for (int i = 0; i < len - 1; i++) load(i, rnd_instr(), 1);
      load(len - 1, ECALL, 1);
      start_run();
      wait_halt(3000);
      chk("rnd_xfer_count", 32'(xfer_edges.size()), 32'(len));
    end
    rnd_mode = 0;
    step();
    issue_ready = 1'b0;
    wb_valid = 1'b0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
